// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with an occupancy count, programmable almost-full and
// almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
// The read side is either first-word-fall-through (FWFT=1) or registered with one cycle of
// latency (FWFT=0).
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush: pointers, level and rd_valid to zero
//   wr_data      write data
//   wr_en        write request, accepted when not full
//   full         level == DEPTH
//   almost_full  level >= AFULL_THRESH
//   rd_en        read/pop request, accepted when not empty
//   rd_data      read data (FWFT: head word; registered: last popped word)
//   rd_valid     FWFT: !empty; registered: one-cycle pulse after an accepted read
//   empty        level == 0
//   almost_empty level <= AEMPTY_THRESH
//   level        occupancy, 0..DEPTH
//   overflow     sticky, a write was rejected because the FIFO was full
//   underflow    sticky, a read was rejected because the FIFO was empty
//   err_clr      synchronous clear of overflow and underflow
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned FWFT          = 1,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   lvl_t;

  localparam lvl_t LvlDepth  = lvl_t'(DEPTH);
  localparam lvl_t LvlAfull  = lvl_t'(AFULL_THRESH);
  localparam lvl_t LvlAempty = lvl_t'(AEMPTY_THRESH);

`ifndef SYNTHESIS
  // Configuration sanity: thresholds outside their legal range make the flags meaningless.
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : gen_bad_afull
    $error("sync_fifo_flags: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : gen_bad_aempty
    $error("sync_fifo_flags: AEMPTY_THRESH must be in 0..DEPTH-1");
  end
`endif

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  lvl_t level_q, level_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;

  // ---------------------------------------------------------------------------------------------
  // Flags come from the level register only, so no request input reaches a flag combinationally.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    full         = (level_q == LvlDepth);
    empty        = (level_q == '0);
    almost_full  = (level_q >= LvlAfull);
    almost_empty = (level_q <= LvlAempty);
  end

  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A flush cycle ignores both requests entirely.
  assign wr_accept = wr_en & ~full & ~clr;
  assign rd_accept = rd_en & ~empty & ~clr;

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   level_d = level_q + lvl_t'(1);
        2'b01:   level_d = level_q - lvl_t'(1);
        default: level_d = level_q;
      endcase
    end

    // Set beats clear when both happen in the same cycle.
    if (wr_en && full && !clr) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end
    if (rd_en && empty && !clr) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  if (FWFT != 0) begin : gen_fwft
    // Head word is visible as soon as it is written; don't-care while empty.
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = ~empty;
  end else begin : gen_reg
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // rd_data holds across idle cycles and across a flush; rd_valid is a one-cycle pulse.
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_accept) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

`ifndef SYNTHESIS
  // Internal consistency: the level never exceeds the depth and matches the pointer distance.
  property p_level_bound;
    @(posedge clk) disable iff (!rst_n) level_q <= LvlDepth;
  endproperty
  a_level_bound: assert property (p_level_bound);

  property p_level_ptrs;
    @(posedge clk) disable iff (!rst_n) ptr_t'(wr_ptr_q - rd_ptr_q) == ptr_t'(level_q);
  endproperty
  a_level_ptrs: assert property (p_level_ptrs);

  property p_full_empty_excl;
    @(posedge clk) disable iff (!rst_n) !(full && empty);
  endproperty
  a_full_empty_excl: assert property (p_full_empty_excl);
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags. Two instances share all inputs: one FWFT, one registered-read.
// A queue-based reference model predicts level, flags and read data; a compare process checks
// both instances every cycle, and directed sequences add literal expectations.
module tb_sync_fifo_flags;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk;
  logic rst_n;
  logic clr;
  logic [DW-1:0] wr_data;
  logic wr_en;
  logic rd_en;
  logic err_clr;

  logic f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_unf;
  logic [DW-1:0] f_rd_data;
  logic [AW:0] f_level;
  logic r_full, r_afull, r_rd_valid, r_empty, r_aempty, r_ovf, r_unf;
  logic [DW-1:0] r_rd_data;
  logic [AW:0] r_level;

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
    .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_aempty), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
  );

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
    .full(r_full), .almost_full(r_afull), .rd_en(rd_en), .rd_data(r_rd_data),
    .rd_valid(r_rd_valid), .empty(r_empty), .almost_empty(r_aempty), .level(r_level),
    .overflow(r_ovf), .underflow(r_unf), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  logic [DW-1:0] m_rd_data = '0;
  bit m_rd_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd_data = '0;
    m_rd_valid = 1'b0;
  endtask

  task automatic model_step();
    int n;
    n = q.size();
    if (!clr && wr_en && n == DEPTH) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
    if (!clr && rd_en && n == 0) m_unf = 1'b1;
    else if (err_clr) m_unf = 1'b0;
    m_rd_valid = 1'b0;
    if (clr) begin
      q.delete();
    end else begin
      if (rd_en && n != 0) begin
        m_rd_data = q.pop_front();
        m_rd_valid = 1'b1;
      end
      if (wr_en && n != DEPTH) q.push_back(wr_data);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("f_level", 32'(f_level), 32'(n));
    chk("r_level", 32'(r_level), 32'(n));
    chk("f_full", 32'(f_full), 32'(n == DEPTH));
    chk("r_full", 32'(r_full), 32'(n == DEPTH));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("r_empty", 32'(r_empty), 32'(n == 0));
    chk("f_afull", 32'(f_afull), 32'(n >= AF));
    chk("r_afull", 32'(r_afull), 32'(n >= AF));
    chk("f_aempty", 32'(f_aempty), 32'(n <= AE));
    chk("r_aempty", 32'(r_aempty), 32'(n <= AE));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("r_ovf", 32'(r_ovf), 32'(m_ovf));
    chk("f_unf", 32'(f_unf), 32'(m_unf));
    chk("r_unf", 32'(r_unf), 32'(m_unf));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
    if (n != 0) chk("f_rd_data", 32'(f_rd_data), 32'(q[0]));
    chk("r_rd_valid", 32'(r_rd_valid), 32'(m_rd_valid));
    chk("r_rd_data", 32'(r_rd_data), 32'(m_rd_data));
  endtask

  // Model advances on each edge from the inputs in force at that edge; outputs are compared
  // shortly afterwards.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #2;
    if (chk_en) compare_all();
  end

  // Apply one cycle of stimulus; returns 1 time unit after the edge with inputs idle.
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c = 1'b0, input logic e = 1'b0);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    clr = c;
    err_clr = e;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    clr = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_level", 32'(f_level), 32'd0);
    chk("rst_empty", 32'(f_empty), 32'd1);
    chk("rst_aempty", 32'(f_aempty), 32'd1);
    chk("rst_full", 32'(f_full), 32'd0);
    chk("rst_afull", 32'(f_afull), 32'd0);
    chk("rst_r_valid", 32'(r_rd_valid), 32'd0);
    chk("rst_r_data", 32'(r_rd_data), 32'd0);
    chk("rst_ovf", 32'(f_ovf), 32'd0);
    chk("rst_unf", 32'(f_unf), 32'd0);
    rst_n = 1'b1;

    // 1. Fill
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      chk("fill_level", 32'(f_level), 32'(i));
      chk("fill_afull", 32'(f_afull), 32'(i >= 14));
      chk("fill_full", 32'(f_full), 32'(i == 16));
      chk("fill_empty", 32'(f_empty), 32'd0);
      if (i == 1) chk("fill_head", 32'(f_rd_data), 32'h0001);
    end

    // 2. Overflow then clear
    drive(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_set", 32'(f_ovf), 32'd1);
    chk("ovf_level", 32'(f_level), 32'd16);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(f_ovf), 32'd0);

    // 3. Drain in order, then underflow, then empty + simultaneous write/read
    for (int i = 1; i <= 16; i++) begin
      chk("drain_head", 32'(f_rd_data), 32'(i));
      drive(1'b0, '0, 1'b1);
      chk("drain_r_data", 32'(r_rd_data), 32'(i));
    end
    chk("drain_empty", 32'(f_empty), 32'd1);
    drive(1'b0, '0, 1'b1);
    chk("unf_set", 32'(f_unf), 32'd1);
    chk("unf_level", 32'(f_level), 32'd0);
    drive(1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
    chk("emp_wr_rd_level", 32'(f_level), 32'd1);
    chk("emp_wr_rd_unf", 32'(f_unf), 32'd1);
    chk("emp_wr_rd_head", 32'(f_rd_data), 32'h5555);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("unf_clr", 32'(f_unf), 32'd0);

    // 4. Wrap-around with constant level
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h0100 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("wrap_head", 32'(f_rd_data), 32'(16'h0100 + k));
      drive(1'b1, 16'(16'h0105 + k), 1'b1);
      chk("wrap_level", 32'(f_level), 32'd5);
    end
    for (int i = 0; i < 11; i++) drive(1'b1, 16'(16'h0200 + i), 1'b0);
    chk("wrap_full", 32'(f_full), 32'd1);
    drive(1'b1, 16'hBEEF, 1'b1);
    chk("full_wr_rd_level", 32'(f_level), 32'd15);
    chk("full_wr_rd_ovf", 32'(f_ovf), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (!f_empty && guard < 20) begin
      drive(1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain_bound", 32'(f_empty), 32'd1);

    // 5. Registered read latency
    drive(1'b1, 16'hABCD, 1'b0);
    chk("reg_idle_valid", 32'(r_rd_valid), 32'd0);
    drive(1'b0, '0, 1'b1);
    chk("reg_valid", 32'(r_rd_valid), 32'd1);
    chk("reg_data", 32'(r_rd_data), 32'hABCD);
    drive(1'b0, '0, 1'b0);
    chk("reg_valid_drop", 32'(r_rd_valid), 32'd0);
    chk("reg_data_hold", 32'(r_rd_data), 32'hABCD);

    // 6. Flush, then asynchronous reset mid-cycle
    for (int i = 0; i < 7; i++) drive(1'b1, 16'(16'h0300 + i), 1'b0);
    chk("pre_clr_level", 32'(f_level), 32'd7);
    drive(1'b1, 16'h0BAD, 1'b1, 1'b1);
    chk("clr_level", 32'(f_level), 32'd0);
    chk("clr_empty", 32'(f_empty), 32'd1);
    chk("clr_ovf", 32'(f_ovf), 32'd0);
    chk("clr_unf", 32'(f_unf), 32'd0);
    chk("clr_r_data", 32'(r_rd_data), 32'hABCD);
    drive(1'b1, 16'h7777, 1'b0);
    chk("post_clr_head", 32'(f_rd_data), 32'h7777);
    drive(1'b1, 16'h7778, 1'b0);
    drive(1'b1, 16'h7779, 1'b0);
    chk("refill_level", 32'(f_level), 32'd3);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_level", 32'(f_level), 32'd0);
    chk("async_empty", 32'(f_empty), 32'd1);
    chk("async_r_level", 32'(r_level), 32'd0);
    chk("async_r_data", 32'(r_rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
